// File: rtl/switch_debounce.sv
// Per-channel two-flop synchroniser followed by a stability counter. A new level
// is accepted only after it has been held for STABLE_CYCLES consecutive clocks.
module switch_debounce #(
  parameter int NUM_SW        = 3,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [NUM_SW-1:0] level_q, level_d;
  logic [NUM_SW-1:0] rise_q,  rise_d;
  logic [NUM_SW-1:0] fall_q,  fall_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      // Any cycle agreeing with the current level restarts qualification.
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Outputs come straight from flops so they can safely clock downstream logic.
  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (NUM_SW=3, STABLE_CYCLES=4): expected pulse events are
// queued when a raw change is driven and matched against DUT pulses as they appear.
`timescale 1ns/1ps
module tb_switch_debounce;

  localparam int NUM_SW  = 3;
  localparam int STABLE  = 4;
  localparam int LATENCY = STABLE + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_level;
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  int          edge_n = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;
  logic [37:0] exp_q[$];  // {edge[31:0], rise[2:0], fall[2:0]}

  switch_debounce #(.NUM_SW(NUM_SW), .STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right after a raw change: pulse expected LATENCY edges later.
  task automatic expect_pulse(input logic [2:0] rise, input logic [2:0] fall);
    exp_q.push_back({32'(edge_n + LATENCY), rise, fall});
  endtask

  task automatic drive_raw(input logic [2:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0 && edge_n > int'(exp_q[0][37:6])) begin
      check_eq("missed_pulse_edge", 32'(edge_n), exp_q[0][37:6]);
      void'(exp_q.pop_front());
    end
    if ((sw_rise | sw_fall) != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {26'd0, sw_rise, sw_fall}, 32'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check_eq("pulse_edge", 32'(edge_n), e[37:6]);
        check_eq("pulse_rise", 32'(sw_rise), 32'(e[5:3]));
        check_eq("pulse_fall", 32'(sw_fall), 32'(e[2:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    sw_raw = 3'b111;

    // 1: reset holds everything at 0, then all channels rise together
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_level", 32'(sw_level), 32'd0);
      check_eq("rst_rise",  32'(sw_rise),  32'd0);
      check_eq("rst_fall",  32'(sw_fall),  32'd0);
    end
    rst = 1'b0;
    expect_pulse(3'b111, 3'b000);
    idle(10);
    check_eq("t1_level", 32'(sw_level), 32'h7);
    drive_raw(3'b000);
    expect_pulse(3'b000, 3'b111);
    idle(10);
    check_eq("t1_release_level", 32'(sw_level), 32'h0);

    // 2: clean press / release on channel 1
    drive_raw(3'b010);
    expect_pulse(3'b010, 3'b000);
    idle(10);
    check_eq("t2_press_level", 32'(sw_level), 32'h2);
    drive_raw(3'b000);
    expect_pulse(3'b000, 3'b010);
    idle(10);
    check_eq("t2_release_level", 32'(sw_level), 32'h0);

    // 3: bounce on channel 0: high 3, low 1, high 2, low 1, then held
    drive_raw(3'b001); idle(2);
    drive_raw(3'b000);
    drive_raw(3'b001); idle(1);
    drive_raw(3'b000);
    drive_raw(3'b001);
    expect_pulse(3'b001, 3'b000);
    idle(LATENCY - 1);
    check_eq("t3_level_before", 32'(sw_level), 32'h0);
    idle(5);
    check_eq("t3_level_after", 32'(sw_level), 32'h1);
    drive_raw(3'b000);
    expect_pulse(3'b000, 3'b001);
    idle(10);

    // 4: short glitch on channel 2 never changes the level
    drive_raw(3'b100); idle(2);
    drive_raw(3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t4_level", 32'(sw_level), 32'h0);
    end

    // 5: reset pulse while channel 0 is at count 2
    drive_raw(3'b001);
    idle(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_rst_level", 32'(sw_level), 32'h0);
    expect_pulse(3'b001, 3'b000);
    idle(10);
    check_eq("t5_level", 32'(sw_level), 32'h1);
    drive_raw(3'b000);
    expect_pulse(3'b000, 3'b001);
    idle(10);

    // 6: channel 0 rises while channel 2 falls in the same clock
    drive_raw(3'b100);
    expect_pulse(3'b100, 3'b000);
    idle(10);
    check_eq("t6_ch2_level", 32'(sw_level), 32'h4);
    drive_raw(3'b001);
    expect_pulse(3'b001, 3'b100);
    idle(10);
    check_eq("t6_level", 32'(sw_level), 32'h1);
    drive_raw(3'b000);
    expect_pulse(3'b000, 3'b001);
    idle(10);

    // ---------------- final report ----------------
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
